fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 53 +++++
 rtl/fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch controller:
//     fetch_state_e     - fetch FSM state encoding
//     INSTR_BYTES       - bytes per instruction word (pc increment / alignment)
//     DEFAULT_RESET_PC  - default first fetch address after reset
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // one cycle after reset before the first request
    REQ   = 2'd1,  // presenting (or ready to present) a fetch request
    WAIT  = 2'd2,  // one request outstanding, response expected
    DRAIN = 2'd3   // outstanding response belongs to a squashed request
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage : fetch_pkg

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
//   One-entry valid/ready holding register between the fetch controller and
//   decode. Holds one instruction word together with its address.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-low reset (clears valid, data and pc)
//   clear      in   synchronous flush; drops the held entry
//   load       in   capture load_data/load_pc and mark the entry valid
//   load_data  in   instruction word to capture
//   load_pc    in   address of load_data
//   valid      out  entry holds an instruction
//   ready      in   consumer takes the entry when valid && ready
//   data       out  held instruction word
//   pc         out  address of the held instruction
// -----------------------------------------------------------------------------
module fetch_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] pc
);

  // Clear wins over load so a flush in the same cycle as a capture leaves the
  // buffer empty. Load and consume never coincide in practice because a new
  // fetch is only issued while the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule : fetch_buf

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Single-outstanding instruction fetch controller. Issues sequential fetch
//   requests to instruction memory, buffers one returned instruction for
//   decode, and handles branch/jump redirects by squashing in-flight work.
//
// Ports
//   clk              in   clock, rising edge
//   rst              in   synchronous, active-low reset
//   redirect_valid   in   single-cycle redirect strobe (highest priority)
//   redirect_target  in   new fetch address (word-aligned internally)
//   imem_req_valid   out  fetch request valid
//   imem_req_addr    out  fetch request address (current pc)
//   imem_req_ready   in   memory accepts the request
//   imem_rsp_valid   in   memory response valid
//   imem_rsp_data    in   fetched instruction word
//   instr_valid      out  buffered instruction available
//   instr_data       out  buffered instruction word
//   instr_pc         out  address of instr_data
//   instr_ready      in   decode consumes the buffered instruction
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   imem_req_valid,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_ready
);

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] req_pc_next;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  buf_valid;
  logic                  buf_load;
  logic                  req_fire;

  // Masking with (INSTR_BYTES-1) forces the redirect address onto an
  // instruction boundary.
  assign redirect_pc = redirect_target & ~ADDR_WIDTH'(INSTR_BYTES - 1);

  // A request is only offered while the decode buffer is empty, so a returned
  // instruction always has somewhere to land.
  assign imem_req_valid = (state == REQ) && !buf_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign instr_valid    = buf_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      req_pc <= req_pc_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    buf_load    = 1'b0;

    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (req_fire) begin
          state_next  = WAIT;
          pc_next     = pc + ADDR_WIDTH'(INSTR_BYTES);
          req_pc_next = pc;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          buf_load   = 1'b1;
          state_next = REQ;
        end
      end
      DRAIN: begin
        // The response for the squashed request is swallowed here.
        if (imem_rsp_valid) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Redirect overrides every other event of the cycle. Whether a request is
    // still in flight decides between re-presenting (REQ) and draining (DRAIN).
    if (redirect_valid) begin
      pc_next  = redirect_pc;
      buf_load = 1'b0;
      case (state)
        REQ:     state_next = req_fire ? DRAIN : REQ;
        WAIT:    state_next = imem_rsp_valid ? REQ : DRAIN;
        // IDLE still goes to REQ. DRAIN stays put unless the pending response
        // arrives in this very cycle; that response is the one being drained,
        // so waiting for another would never terminate.
        default: begin
        end
      endcase
    end
  end

  fetch_buf #(
    .DATA_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .load      (buf_load),
    .load_data (imem_rsp_data),
    .load_pc   (req_pc),
    .valid     (buf_valid),
    .ready     (instr_ready),
    .data      (instr_data),
    .pc        (instr_pc)
  );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int          AW  = 32;
  localparam int          IW  = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready = 1'b0;
  logic          imem_rsp_valid = 1'b0;
  logic [IW-1:0] imem_rsp_data = '0;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  fetch_ctrl #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .RESET_PC    (RPC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Inputs are driven and outputs sampled at falling edges.
  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0F00;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin failures++; $display("FAIL reset_instr_data got=%h exp=0", instr_data); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
    checks++; if (imem_req_addr !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", imem_req_addr, RPC); end
    do_reset();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin failures++; $display("FAIL reset_first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [31:0] addr_q[$];
    logic [31:0] pcs_q[$];
    logic [31:0] dat_q[$];
    int          cyc_q[$];
    logic        hs_prev;
    logic [31:0] last;
    hs_prev = 1'b0;
    last = '0;
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (instr_valid) begin
        pcs_q.push_back(instr_pc);
        dat_q.push_back(instr_data);
      end
      imem_rsp_valid = hs_prev;
      imem_rsp_data = hs_prev ? instr_of(last) : '0;
      hs_prev = imem_req_valid;
      if (hs_prev) begin
        addr_q.push_back(imem_req_addr);
        cyc_q.push_back(c);
        last = imem_req_addr;
      end
      @(negedge clk);
    end
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (addr_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", i, addr_q[i], 32'(4 * i)); end
      checks++; if (pcs_q[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_instr_pc[%0d] got=%h exp=%h", i, pcs_q[i], 32'(4 * i)); end
      checks++; if (dat_q[i] !== instr_of(32'(4 * i))) begin failures++; $display("FAIL stream_instr_data[%0d] got=%h exp=%h", i, dat_q[i], instr_of(32'(4 * i))); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (cyc_q[i+1] - cyc_q[i] != 3) begin failures++; $display("FAIL stream_req_spacing[%0d] got=%0d exp=3", i, cyc_q[i+1] - cyc_q[i]); end
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = instr_of(32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/00000004", k, imem_req_valid, imem_req_addr); end
      if (k == 3) imem_req_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h8) begin failures++; $display("FAIL stall_after_hs got=%b/%h exp=0/00000008", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = instr_of(32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== instr_of(32'h0)) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%h exp=1/00000000/%h", k, instr_valid, instr_pc, instr_data, instr_of(32'h0)); end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_no_req[%0d] got=%b exp=0", k, imem_req_valid); end
      if (k == 3) instr_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bp_consumed got=%b exp=0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL bp_next_req got=%b/%h exp=1/00000004", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_target = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = instr_of(32'h0);
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rdw_drain got=%b/%b exp=0/0", imem_req_valid, instr_valid); end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL rdw_new_req got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdw_old_dropped got=%b exp=0", instr_valid); end
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = instr_of(32'h100);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdw_wait_empty got=%b exp=0", instr_valid); end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== instr_of(32'h100)) begin failures++; $display("FAIL rdw_new_instr got=%b/%h/%h exp=1/00000100/%h", instr_valid, instr_pc, instr_data, instr_of(32'h100)); end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = instr_of(32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL rdr_buf_full got=%b exp=1", instr_valid); end
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdr_buf_flushed got=%b exp=0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin failures++; $display("FAIL rdr_req_300 got=%b/%h exp=1/00000300", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = instr_of(32'h300);
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdr_rsp_dropped got=%b exp=0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL rdr_req_200 got=%b/%h exp=1/00000200", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdr_still_empty got=%b exp=0", instr_valid); end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rmid_after_reset got=%b/%b exp=0/0", imem_req_valid, instr_valid); end
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin failures++; $display("FAIL rmid_first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RPC); end
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rmid_late_rsp[%0d] got=%b exp=0", k, instr_valid); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin failures++; $display("FAIL rmid_req_hold[%0d] got=%b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, RPC); end
      @(negedge clk);
    end
  endtask

  // Transaction-level model: expected fetch address stream, at most one
  // outstanding memory access, and a queue of instructions owed to decode.
  task automatic test_random();
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_dat_q[$];
    logic [31:0] model_pc;
    logic [31:0] mem_addr;
    logic [31:0] prev_addr;
    logic        mem_busy;
    logic        stale;
    logic        prev_wait;
    int          delay;
    int          delivered;
    do_reset();
    model_pc = RPC;
    mem_addr = '0;
    prev_addr = '0;
    mem_busy = 1'b0;
    stale = 1'b0;
    prev_wait = 1'b0;
    delay = 0;
    delivered = 0;
    for (int c = 0; c < 2000; c++) begin
      checks++; if (instr_valid !== (exp_pc_q.size() != 0)) begin failures++; $display("FAIL rnd_instr_valid cyc=%0d got=%b exp=%b", c, instr_valid, exp_pc_q.size() != 0); end
      if (instr_valid === 1'b1 && exp_pc_q.size() != 0) begin
        checks++; if (instr_pc !== exp_pc_q[0] || instr_data !== exp_dat_q[0]) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h/%h exp=%h/%h", c, instr_pc, instr_data, exp_pc_q[0], exp_dat_q[0]); end
      end
      if (mem_busy) begin
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rnd_one_outstanding cyc=%0d got=%b exp=0", c, imem_req_valid); end
      end
      if (prev_wait) begin
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin failures++; $display("FAIL rnd_req_hold cyc=%0d got=%b/%h exp=1/%h", c, imem_req_valid, imem_req_addr, prev_addr); end
      end

      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_target = $urandom();
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom();
      if (mem_busy) begin
        if (delay == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = instr_of(mem_addr);
        end else begin
          delay--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        imem_rsp_valid = 1'b1;
      end

      if (instr_valid === 1'b1 && instr_ready && exp_pc_q.size() != 0) begin
        void'(exp_pc_q.pop_front());
        void'(exp_dat_q.pop_front());
        delivered++;
      end
      if (imem_rsp_valid && mem_busy) begin
        mem_busy = 1'b0;
        if (!stale) begin
          exp_pc_q.push_back(mem_addr);
          exp_dat_q.push_back(imem_rsp_data);
        end
      end
      if (imem_req_valid === 1'b1 && imem_req_ready) begin
        checks++; if (imem_req_addr !== model_pc) begin failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", c, imem_req_addr, model_pc); end
        model_pc = model_pc + 32'd4;
        mem_busy = 1'b1;
        mem_addr = imem_req_addr;
        stale = 1'b0;
        delay = $urandom_range(0, 3);
      end
      if (redirect_valid) begin
        model_pc = {redirect_target[31:2], 2'b00};
        exp_pc_q.delete();
        exp_dat_q.delete();
        if (mem_busy) stale = 1'b1;
      end
      prev_wait = (imem_req_valid === 1'b1) && !imem_req_ready && !redirect_valid;
      prev_addr = imem_req_addr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    checks++; if (delivered < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", delivered); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_req_stall();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_ctrl
